// File: rtl/spi_cfg_pkg.sv
// -----------------------------------------------------------------------------
// spi_cfg_pkg
// Shared types and constants for the SPI configuration receiver.
//   FRAME_BITS  : exact number of SCLK rising edges in a valid frame
//   CNT_W       : width of the saturating bit counter
//   wave_sel_t  : waveform shape encoding driven to the shape mux
//   state_t     : receiver FSM states
//   cfg_frame_t : frame layout as shifted in, MSB first
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package spi_cfg_pkg;

  localparam int FRAME_BITS = 18;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    SINE     = 2'b00,
    SQUARE   = 2'b01,
    TRIANGLE = 2'b10,
    SAWTOOTH = 2'b11
  } wave_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    CHECK = 2'b10
  } state_t;

  typedef struct packed {
    logic [15:0] divider;
    wave_sel_t   wave_sel;
  } cfg_frame_t;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer for one asynchronous input, with registered
// rising/falling edge pulses taken from one extra flop behind the chain.
//   clk, rst_n : local clock, synchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level (STAGES flops after din)
//   rise, fall : one-cycle registered edge pulses on the synchronized level
// Edges are suppressed until the chain and the extra flop hold real samples,
// so the reset level can never masquerade as a transition. A pin already at
// the opposite level when reset releases therefore produces no edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   primed_q;

  assign level = sync_q[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchronizer chain into a single flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= {STAGES{RESET_LEVEL}};
      prev_q   <= RESET_LEVEL;
      primed_q <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], din};
      prev_q   <= sync_q[STAGES-1];
      primed_q <= {primed_q[STAGES-1:0], 1'b1};
      rise     <= primed_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
      fall     <= primed_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;
    end
  end

endmodule

// File: rtl/spi_cfg_receiver.sv
// -----------------------------------------------------------------------------
// spi_cfg_receiver
// SPI mode-0 slave receiving the 18-bit frame {divider[15:0], wave_sel[1:0]},
// MSB first, and holding the last accepted configuration.
//   clk, rst_n  : 12 MHz system clock, synchronous active-low reset
//   sclk, mosi  : SPI clock/data from the master (asynchronous)
//   cs_n        : SPI chip select, active low (asynchronous)
//   wave_sel    : held waveform select
//   divider     : held phase-step divider
//   cfg_valid   : one-cycle pulse, wave_sel/divider just updated
//   frame_error : one-cycle pulse, frame rejected (bad length or divider)
//   busy        : high while a frame is being received or checked
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_cfg_receiver
  import spi_cfg_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MIN_DIV     = 16'd2,
  parameter logic [15:0] DIV_RESET   = 16'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic [1:0]  wave_sel,
  output logic [15:0] divider,
  output logic        cfg_valid,
  output logic        frame_error,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Input conditioning: equal depth on all three pins keeps mosi aligned with
  // the sclk edge that samples it.
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall_unused, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [FRAME_BITS-1:0]  shift_q;
  cfg_frame_t             rx_frame;
  logic                   accept;
  logic                   valid_d, error_d;
  logic [15:0]            divider_q;
  wave_sel_t              wave_sel_q;

  assign rx_frame = cfg_frame_t'(shift_q);
  assign accept   = (bit_cnt_q == CNT_W'(FRAME_BITS)) && (rx_frame.divider >= MIN_DIV);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      IDLE:  if (cs_fall) state_d = SHIFT;
      SHIFT: if (cs_rise) state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        valid_d = accept;
        error_d = ~accept;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register and saturating counter. A cs_n rise in the same cycle as
  // an sclk rise ends the frame, so that sclk edge is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q == IDLE && cs_fall) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q == SHIFT && sclk_rise && !cs_rise) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt_q != {CNT_W{1'b1}}) bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  // Held configuration and result pulses, registered on the edge leaving CHECK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divider_q   <= DIV_RESET;
      wave_sel_q  <= SINE;
      cfg_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cfg_valid   <= valid_d;
      frame_error <= error_d;
      if (valid_d) begin
        divider_q  <= rx_frame.divider;
        wave_sel_q <= rx_frame.wave_sel;
      end
    end
  end

  assign divider  = divider_q;
  assign wave_sel = wave_sel_q;
  assign busy     = (state_q != IDLE);

endmodule
